// File: rtl/nonsynth_ethernet_rx_ctrl_if.sv
// Buffer-read, frame-status and output-stream bundle for the Ethernet RX sequencer.
// master = sequencer side; slave = receiver buffer + stream consumer side.
interface nonsynth_ethernet_rx_ctrl_if #(
  parameter int buf_size_p   = 1560,
  parameter int recv_width_p = 8
);
  localparam int addr_width_lp = $clog2(buf_size_p / recv_width_p);

  logic                     rx_full_i;
  logic [15:0]              rx_size_i;
  logic                     rd_v_o;
  logic [addr_width_lp-1:0] rd_addr_o;
  logic [63:0]              rd_data_i;
  logic                     clear_buffer_o;
  logic [63:0]              data_o;
  logic [7:0]               keep_o;
  logic                     last_o;
  logic                     v_o;
  logic                     ready_i;

  modport master (
    input  rx_full_i, rx_size_i, rd_data_i, ready_i,
    output rd_v_o, rd_addr_o, clear_buffer_o,
    output data_o, keep_o, last_o, v_o
  );

  modport slave (
    output rx_full_i, rx_size_i, rd_data_i, ready_i,
    input  rd_v_o, rd_addr_o, clear_buffer_o,
    input  data_o, keep_o, last_o, v_o
  );
endinterface

// File: rtl/nonsynth_ethernet_rx_ctrl.sv
// Ethernet RX sequencer: waits for a full frame in the word buffer, streams it
// out with keep/last, then pulses clear_buffer; illegal/disabled frames are dropped.
// Ports: clk_i, reset_i (sync, active high), enable_i, bus (master: rx status,
// buffer read, clear pulse, output stream), busy_o, frames_delivered_o, frames_dropped_o.
module nonsynth_ethernet_rx_ctrl #(
  parameter int recv_width_p = 8,
  parameter int buf_size_p   = 1560
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  nonsynth_ethernet_rx_ctrl_if.master bus,
  output logic        busy_o,
  output logic [31:0] frames_delivered_o,
  output logic [31:0] frames_dropped_o
);
  localparam int aw_lp = $clog2(buf_size_p / recv_width_p);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_CLEAR,
    S_DRAIN
  } state_e;

  state_e           r_state;
  logic [15:0]      r_size;
  logic [aw_lp:0]   r_words;
  logic [aw_lp:0]   r_idx;
  logic             r_first;
  logic [63:0]      r_data;
  logic             r_rd_v;
  logic [aw_lp-1:0] r_rd_addr;
  logic             r_clear;
  logic             r_v;
  logic             r_last;
  logic [7:0]       r_keep;
  logic             r_busy;
  logic [31:0]      r_deliv;
  logic [31:0]      r_drop;

  logic             w_size_ok;
  logic [16:0]      w_words_ext;
  logic             w_last;
  logic [15:0]      w_rem;
  logic [8:0]       w_mask;
  logic [7:0]       w_keep;
  logic [aw_lp:0]   w_idx_nx;

  always_ff @(posedge clk_i) begin
    assert (recv_width_p == 8 && (buf_size_p % recv_width_p) == 0)
      else $error("unsupported recv_width_p/buf_size_p");
  end

  assign w_size_ok   = (bus.rx_size_i != 16'd0) &&
                       (bus.rx_size_i <= 16'(buf_size_p));
  assign w_words_ext = ({1'b0, bus.rx_size_i} + 17'd7) >> 3;
  assign w_last      = (r_idx == r_words - (aw_lp+1)'(1));
  assign w_rem       = r_size - 16'({r_idx, 3'b000});
  // rem is 1..8 on the last word; 8 must map to a full mask
  assign w_mask      = (9'd1 << w_rem[3:0]) - 9'd1;
  assign w_keep      = (w_rem >= 16'd8) ? 8'hFF : w_mask[7:0];
  assign w_idx_nx    = r_idx + (aw_lp+1)'(1);

  assign bus.rd_v_o         = r_rd_v;
  assign bus.rd_addr_o      = r_rd_addr;
  assign bus.clear_buffer_o = r_clear;
  // First SEND cycle forwards the buffer word; afterwards the captured copy
  // holds it stable under backpressure.
  assign bus.data_o         = r_first ? bus.rd_data_i : r_data;
  assign bus.keep_o         = r_keep;
  assign bus.last_o         = r_last;
  assign bus.v_o            = r_v;
  assign busy_o             = r_busy;
  assign frames_delivered_o = r_deliv;
  assign frames_dropped_o   = r_drop;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_size    <= '0;
      r_words   <= '0;
      r_idx     <= '0;
      r_first   <= 1'b0;
      r_data    <= '0;
      r_rd_v    <= 1'b0;
      r_rd_addr <= '0;
      r_clear   <= 1'b0;
      r_v       <= 1'b0;
      r_last    <= 1'b0;
      r_keep    <= '0;
      r_busy    <= 1'b0;
      r_deliv   <= '0;
      r_drop    <= '0;
    end else begin
      r_rd_v  <= 1'b0;
      r_clear <= 1'b0;
      r_first <= 1'b0;
      if (r_first)
        r_data <= bus.rd_data_i;

      unique case (r_state)
        S_IDLE: begin
          if (bus.rx_full_i) begin
            r_busy <= 1'b1;
            if (enable_i && w_size_ok) begin
              r_state   <= S_READ;
              r_size    <= bus.rx_size_i;
              r_words   <= w_words_ext[aw_lp:0];
              r_idx     <= '0;
              r_rd_v    <= 1'b1;
              r_rd_addr <= '0;
            end else begin
              r_state <= S_CLEAR;
              r_clear <= 1'b1;
              r_drop  <= r_drop + 32'd1;
            end
          end
        end
        S_READ: begin
          r_state <= S_SEND;
          r_v     <= 1'b1;
          r_first <= 1'b1;
          r_last  <= w_last;
          r_keep  <= w_last ? w_keep : 8'hFF;
        end
        S_SEND: begin
          if (bus.ready_i) begin
            r_v <= 1'b0;
            if (r_last) begin
              r_state <= S_CLEAR;
              r_clear <= 1'b1;
              r_deliv <= r_deliv + 32'd1;
            end else begin
              r_state   <= S_READ;
              r_idx     <= w_idx_nx;
              r_rd_v    <= 1'b1;
              r_rd_addr <= w_idx_nx[aw_lp-1:0];
            end
          end
        end
        S_CLEAR: begin
          r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          // a stale rx_full must not restart the frame just cleared
          if (!bus.rx_full_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nonsynth_ethernet_rx_ctrl.sv
// Randomized self-checking bench for nonsynth_ethernet_rx_ctrl.
// Frame-level reference model: expected word queue, counters, clear pulses.
module tb_nonsynth_ethernet_rx_ctrl;
  localparam int BUF = 1560;
  localparam int NW  = BUF / 8;

  logic        clk;
  logic        reset_i;
  logic        enable_i;
  logic        busy_o;
  logic [31:0] frames_delivered_o;
  logic [31:0] frames_dropped_o;

  nonsynth_ethernet_rx_ctrl_if #(.buf_size_p(BUF)) bus();

  nonsynth_ethernet_rx_ctrl #(
    .recv_width_p(8),
    .buf_size_p  (BUF)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .enable_i          (enable_i),
    .bus               (bus),
    .busy_o            (busy_o),
    .frames_delivered_o(frames_delivered_o),
    .frames_dropped_o  (frames_dropped_o)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    int          addr;
  } exp_t;

  exp_t        q[$];
  logic [63:0] mem[NW];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          clr_cnt = 0;
  int          clr_cyc = 0;
  int          rdv_cnt = 0;
  int          v_cnt   = 0;
  int          rdy_mode = 0;
  int          exp_deliv = 0;
  int          exp_drop  = 0;
  logic        p_v, p_rdy, p_last;
  logic [63:0] p_data;
  logic [7:0]  p_keep;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.ready_i = 1'b1;
      1:       bus.ready_i = 1'($urandom_range(0, 1));
      default: bus.ready_i = 1'b0;
    endcase
  end

  // synchronous buffer: word appears the cycle after the read strobe,
  // garbage otherwise so a missed capture is visible
  always @(posedge clk) begin
    if (bus.rd_v_o)
      bus.rd_data_i <= mem[bus.rd_addr_o];
    else
      bus.rd_data_i <= {$urandom, $urandom};
  end

  always @(negedge clk) begin
    if (reset_i) begin
      p_v = 1'b0;
    end else begin
      if (bus.clear_buffer_o) begin
        clr_cnt++;
        clr_cyc = cyc;
      end
      if (bus.rd_v_o) begin
        rdv_cnt++;
        if (q.size() > 0)
          chk("rd_addr", 64'(bus.rd_addr_o), 64'(q[0].addr));
        else
          chk("rd_spurious", 64'd1, 64'd0);
      end
      if (bus.v_o) v_cnt++;
      if (p_v && !p_rdy) begin
        chk("hold_v", 64'(bus.v_o), 64'd1);
        chk("hold_data", bus.data_o, p_data);
        chk("hold_keep", 64'(bus.keep_o), 64'(p_keep));
        chk("hold_last", 64'(bus.last_o), 64'(p_last));
      end
      if (bus.v_o && bus.ready_i) begin
        if (q.size() == 0) begin
          chk("extra_word", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("data", bus.data_o, e.data);
          chk("keep", 64'(bus.keep_o), 64'(e.keep));
          chk("last", 64'(bus.last_o), 64'(e.last));
        end
      end
      p_v    = bus.v_o;
      p_rdy  = bus.ready_i;
      p_data = bus.data_o;
      p_keep = bus.keep_o;
      p_last = bus.last_o;
    end
  end

  task automatic load_frame(input int size, input bit deliver);
    int words;
    int nb;
    exp_t e;
    for (int i = 0; i < NW; i++) mem[i] = {$urandom, $urandom};
    if (deliver) begin
      words = (size + 7) / 8;
      for (int i = 0; i < words; i++) begin
        nb = size - 8 * i;
        if (nb > 8) nb = 8;
        e.data = mem[i];
        e.keep = 8'((16'h1 << nb) - 1);
        e.last = (i == words - 1);
        e.addr = i;
        q.push_back(e);
      end
    end
  endtask

  task automatic run_frame(input int size, input bit en, input int mode);
    bit deliver;
    int c0, r0, v0, t0, n;
    deliver = en && size >= 1 && size <= BUF;
    load_frame(size, deliver);
    if (deliver) exp_deliv++;
    else exp_drop++;
    c0 = clr_cnt;
    r0 = rdv_cnt;
    v0 = v_cnt;
    rdy_mode = mode;
    @(posedge clk); #1;
    bus.rx_size_i = 16'(size);
    enable_i      = en;
    bus.rx_full_i = 1'b1;
    t0 = cyc;
    n = 0;
    while (clr_cnt == c0 && n < 5000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("clr_seen", 64'(clr_cnt != c0), 64'd1);
    if (!deliver)
      chk("drop_lat", 64'(clr_cyc - t0 <= 2), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    bus.rx_full_i = 1'b0;
    bus.rx_size_i = 16'($urandom);
    enable_i      = 1'($urandom);
    n = 0;
    while (busy_o && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle", 64'(busy_o), 64'd0);
    chk("q_empty", 64'(q.size()), 64'd0);
    q.delete();
    chk("clr_cnt", 64'(clr_cnt - c0), 64'd1);
    chk("delivered", 64'(frames_delivered_o), 64'(exp_deliv));
    chk("dropped", 64'(frames_dropped_o), 64'(exp_drop));
    if (!deliver) begin
      chk("drop_no_rd", 64'(rdv_cnt - r0), 64'd0);
      chk("drop_no_v", 64'(v_cnt - v0), 64'd0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_v"}, 64'(bus.rd_v_o), 64'd0);
    chk({tag, "_rd_addr"}, 64'(bus.rd_addr_o), 64'd0);
    chk({tag, "_clear"}, 64'(bus.clear_buffer_o), 64'd0);
    chk({tag, "_v"}, 64'(bus.v_o), 64'd0);
    chk({tag, "_data"}, bus.data_o, 64'd0);
    chk({tag, "_keep"}, 64'(bus.keep_o), 64'd0);
    chk({tag, "_last"}, 64'(bus.last_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_deliv"}, 64'(frames_delivered_o), 64'd0);
    chk({tag, "_drop"}, 64'(frames_dropped_o), 64'd0);
  endtask

  task automatic reset_mid_frame();
    int c0, n;
    load_frame(64, 1'b1);
    rdy_mode = 0;
    @(posedge clk); #1;
    bus.rx_size_i = 16'd64;
    enable_i      = 1'b1;
    bus.rx_full_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!(bus.v_o && q.size() > 0 && q[0].addr == 3) && n < 200);
    chk("word3_reached", 64'(n < 200), 64'd1);
    reset_i = 1'b1;
    c0 = clr_cnt;
    @(posedge clk); #1;
    chk_zero("mid_rst");
    exp_deliv = 0;
    exp_drop  = 0;
    bus.rx_full_i = 1'b0;
    q.delete();
    @(posedge clk); #1;
    reset_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_no_clr", 64'(clr_cnt - c0), 64'd0);
    chk("mid_rst_idle", 64'(busy_o), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int size, r;
    bit en;
    reset_i       = 1'b1;
    enable_i      = 1'b0;
    bus.rx_full_i = 1'b0;
    bus.rx_size_i = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset_i = 1'b0;
    @(posedge clk); #1;

    run_frame(64, 1'b1, 0);
    run_frame(61, 1'b1, 0);
    run_frame(1, 1'b1, 0);
    run_frame(60, 1'b1, 1);
    run_frame(64, 1'b0, 0);
    run_frame(0, 1'b1, 0);
    run_frame(1600, 1'b1, 0);
    run_frame(1560, 1'b1, 1);
    run_frame(1561, 1'b1, 0);

    reset_mid_frame();

    run_frame(1514, 1'b1, 0);
    run_frame(8, 1'b1, 0);

    for (int k = 0; k < 12; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) size = 0;
      else if (r == 1) size = $urandom_range(1561, 4000);
      else if (r < 6) size = $urandom_range(1, 64);
      else size = $urandom_range(1, BUF);
      en = ($urandom_range(0, 5) != 0);
      run_frame(size, en, $urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
